// File: rtl/level_trigger_multi.sv
// Multi-channel level trigger with per-channel hysteresis and holdoff.
// The block sits inline on an AXI4-Stream path and adds one register stage.
// Trigger flags leave on the same beat as the data that caused them.
module level_trigger_multi #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned CH_W      = 16,
    parameter int unsigned HOLDOFF_W = 16
) (
    input  logic                     stream_clk,
    input  logic                     resetn,
    output logic                     s_tready,
    input  logic                     s_tvalid,
    input  logic [NUM_CH*CH_W-1:0]   s_tdata,
    input  logic                     m_tready,
    output logic                     m_tvalid,
    output logic [NUM_CH*CH_W-1:0]   m_tdata,
    input  logic [NUM_CH*CH_W-1:0]   level,
    input  logic [NUM_CH*CH_W-1:0]   hyst,
    input  logic [HOLDOFF_W-1:0]     holdoff,
    output logic [NUM_CH-1:0]        trig_rising,
    output logic [NUM_CH-1:0]        trig_falling,
    output logic                     trig_any
);

    // Two guard bits keep L-h and L+h free of wrap for any L and h.
    localparam int unsigned EXT_W = CH_W + 2;

    typedef enum logic [1:0] {
        ST_MID   = 2'd0,
        ST_BELOW = 2'd1,
        ST_ABOVE = 2'd2
    } ch_state_t;

    logic              acc;
    logic [NUM_CH-1:0] trig_rise_c;
    logic [NUM_CH-1:0] trig_fall_c;

    // Ready whenever the output register is empty or being drained this cycle.
    assign s_tready = !m_tvalid || m_tready;
    assign acc      = s_tvalid && s_tready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic signed [EXT_W-1:0] x_e;
        logic signed [EXT_W-1:0] l_e;
        logic signed [EXT_W-1:0] h_e;
        logic signed [EXT_W-1:0] lo_e;
        logic signed [EXT_W-1:0] hi_e;
        ch_state_t               state_q;
        ch_state_t               state_d;
        logic [HOLDOFF_W-1:0]    cnt_q;
        logic [HOLDOFF_W-1:0]    cnt_d;
        logic                    rise_evt;
        logic                    fall_evt;
        logic                    rise_trig;
        logic                    fall_trig;

        assign x_e  = {{2{s_tdata[i*CH_W + CH_W - 1]}}, s_tdata[i*CH_W +: CH_W]};
        assign l_e  = {{2{level[i*CH_W + CH_W - 1]}}, level[i*CH_W +: CH_W]};
        assign h_e  = {2'b00, hyst[i*CH_W +: CH_W]};
        assign lo_e = l_e - h_e;
        assign hi_e = l_e + h_e;

        // Channel state and holdoff counter registers.
        always_ff @(posedge stream_clk or negedge resetn) begin
            if (!resetn) begin
                state_q <= ST_MID;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Hysteresis FSM, crossing events and holdoff; advances only on an accepted beat.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            rise_evt  = 1'b0;
            fall_evt  = 1'b0;
            rise_trig = 1'b0;
            fall_trig = 1'b0;
            if (acc) begin
                rise_evt  = (state_q == ST_BELOW) && (x_e >= l_e);
                fall_evt  = (state_q == ST_ABOVE) && (x_e <= l_e);
                rise_trig = rise_evt && (cnt_q == '0);
                fall_trig = fall_evt && (cnt_q == '0);

                if (x_e < lo_e) begin
                    state_d = ST_BELOW;
                end else if (x_e > hi_e) begin
                    state_d = ST_ABOVE;
                end else if (rise_evt || fall_evt) begin
                    state_d = ST_MID;
                end

                if (rise_trig || fall_trig) begin
                    cnt_d = holdoff;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - HOLDOFF_W'(1);
                end
            end
        end

        assign trig_rise_c[i] = rise_trig;
        assign trig_fall_c[i] = fall_trig;
    end

    // Output register stage: load on accept, clear valid and flags once drained.
    always_ff @(posedge stream_clk or negedge resetn) begin
        if (!resetn) begin
            m_tvalid     <= 1'b0;
            m_tdata      <= '0;
            trig_rising  <= '0;
            trig_falling <= '0;
            trig_any     <= 1'b0;
        end else if (acc) begin
            m_tvalid     <= 1'b1;
            m_tdata      <= s_tdata;
            trig_rising  <= trig_rise_c;
            trig_falling <= trig_fall_c;
            trig_any     <= |{trig_rise_c, trig_fall_c};
        end else if (m_tready) begin
            m_tvalid     <= 1'b0;
            trig_rising  <= '0;
            trig_falling <= '0;
            trig_any     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_level_trigger_multi.sv
// Directed bench for level_trigger_multi plus a randomised scoreboard run.
module tb_level_trigger_multi;

    localparam int unsigned NUM_CH    = 2;
    localparam int unsigned CH_W      = 16;
    localparam int unsigned HOLDOFF_W = 16;

    logic                    stream_clk = 1'b0;
    logic                    resetn     = 1'b0;
    logic                    s_tready;
    logic                    s_tvalid   = 1'b0;
    logic [NUM_CH*CH_W-1:0]  s_tdata    = '0;
    logic                    m_tready   = 1'b1;
    logic                    m_tvalid;
    logic [NUM_CH*CH_W-1:0]  m_tdata;
    logic [NUM_CH*CH_W-1:0]  level      = '0;
    logic [NUM_CH*CH_W-1:0]  hyst       = '0;
    logic [HOLDOFF_W-1:0]    holdoff    = '0;
    logic [NUM_CH-1:0]       trig_rising;
    logic [NUM_CH-1:0]       trig_falling;
    logic                    trig_any;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: 0 = MID, 1 = BELOW, 2 = ABOVE.
    int mst  [NUM_CH];
    int mcnt [NUM_CH];
    logic [36:0] sbq [$];
    int n_popped = 0;

    level_trigger_multi #(
        .NUM_CH    (NUM_CH),
        .CH_W      (CH_W),
        .HOLDOFF_W (HOLDOFF_W)
    ) dut (
        .stream_clk   (stream_clk),
        .resetn       (resetn),
        .s_tready     (s_tready),
        .s_tvalid     (s_tvalid),
        .s_tdata      (s_tdata),
        .m_tready     (m_tready),
        .m_tvalid     (m_tvalid),
        .m_tdata      (m_tdata),
        .level        (level),
        .hyst         (hyst),
        .holdoff      (holdoff),
        .trig_rising  (trig_rising),
        .trig_falling (trig_falling),
        .trig_any     (trig_any)
    );

    initial forever #5 stream_clk = ~stream_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply reset with new thresholds, check reset outputs, release and idle one clock.
    task automatic do_reset(input logic [15:0] l0, input logic [15:0] l1,
                            input logic [15:0] h0, input logic [15:0] h1,
                            input logic [15:0] ho);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        resetn   = 1'b0;
        level    = {l1, l0};
        hyst     = {h1, h0};
        holdoff  = ho;
        #2;
        check("rst.valid", 64'(m_tvalid), 64'd0);
        check("rst.data",  64'(m_tdata), 64'd0);
        check("rst.rise",  64'(trig_rising), 64'd0);
        check("rst.fall",  64'(trig_falling), 64'd0);
        check("rst.any",   64'(trig_any), 64'd0);
        @(negedge stream_clk);
        resetn = 1'b1;
        @(posedge stream_clk);
        #1;
    endtask

    // Present one beat with m_tready high and check the registered result.
    task automatic beat(input string tag, input logic [15:0] c0, input logic [15:0] c1,
                        input logic [1:0] er, input logic [1:0] ef);
        s_tdata  = {c1, c0};
        s_tvalid = 1'b1;
        @(posedge stream_clk);
        #1;
        check({tag, ".valid"}, 64'(m_tvalid), 64'd1);
        check({tag, ".data"},  64'(m_tdata), 64'({c1, c0}));
        check({tag, ".rise"},  64'(trig_rising), 64'(er));
        check({tag, ".fall"},  64'(trig_falling), 64'(ef));
        check({tag, ".any"},   64'(trig_any), 64'(|{er, ef}));
    endtask

    task automatic model_reset();
        for (int c = 0; c < int'(NUM_CH); c++) begin
            mst[c]  = 0;
            mcnt[c] = 0;
        end
    endtask

    // Expected output word {data, rise, fall, any} for one accepted beat.
    task automatic model_beat(input logic [31:0] d, output logic [36:0] exp);
        logic [1:0] r;
        logic [1:0] f;
        int x;
        int lv;
        int hv;
        bit re;
        bit fe;
        r = '0;
        f = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            x  = int'($signed(d[c*16 +: 16]));
            lv = int'($signed(level[c*16 +: 16]));
            hv = int'(hyst[c*16 +: 16]);
            re = (mst[c] == 1) && (x >= lv);
            fe = (mst[c] == 2) && (x <= lv);
            if ((re || fe) && mcnt[c] == 0) begin
                r[c]    = re;
                f[c]    = fe;
                mcnt[c] = int'(holdoff);
            end else if (mcnt[c] > 0) begin
                mcnt[c] = mcnt[c] - 1;
            end
            if (x < lv - hv)       mst[c] = 1;
            else if (x > lv + hv)  mst[c] = 2;
            else if (re || fe)     mst[c] = 0;
        end
        exp = {d, r, f, |{r, f}};
    endtask

    // Sample both handshakes on the falling edge; pop before push since latency is >= 1.
    task automatic sb_cycle();
        logic [36:0] e;
        @(negedge stream_clk);
        if (m_tvalid && m_tready) begin
            if (sbq.size() == 0) begin
                check("sb.dup", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                n_popped++;
                check("sb.beat", 64'({m_tdata, trig_rising, trig_falling, trig_any}), 64'(e));
            end
        end
        if (s_tvalid && s_tready) begin
            model_beat(s_tdata, e);
            sbq.push_back(e);
        end
        @(posedge stream_clk);
        #1;
    endtask

    initial begin
        // Plain crossings, L=0 h=0; ch1 stays above and never fires.
        do_reset(16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        beat("t1.b0", 16'd100,    16'd7, 2'b00, 2'b00);
        beat("t1.b1", 16'(-5),    16'd7, 2'b00, 2'b01);
        beat("t1.b2", 16'd0,      16'd7, 2'b01, 2'b00);
        beat("t1.b3", 16'd5,      16'd7, 2'b00, 2'b00);
        beat("t1.b4", 16'd0,      16'd7, 2'b00, 2'b01);

        // Hysteresis band 80..120 around L=100.
        do_reset(16'd100, 16'd100, 16'd20, 16'd20, 16'd0);
        beat("t2.b0", 16'd90,  16'd100, 2'b00, 2'b00);
        beat("t2.b1", 16'd110, 16'd100, 2'b00, 2'b00);
        beat("t2.b2", 16'd85,  16'd100, 2'b00, 2'b00);
        beat("t2.b3", 16'd110, 16'd100, 2'b00, 2'b00);
        beat("t2.b4", 16'd70,  16'd100, 2'b00, 2'b00);
        beat("t2.b5", 16'd110, 16'd100, 2'b01, 2'b00);

        // Holdoff of 3 suppresses the next three crossings.
        do_reset(16'd0, 16'd0, 16'd0, 16'd0, 16'd3);
        beat("t3.b0", 16'(-1), 16'd0, 2'b00, 2'b00);
        beat("t3.b1", 16'd1,   16'd0, 2'b01, 2'b00);
        beat("t3.b2", 16'(-1), 16'd0, 2'b00, 2'b00);
        beat("t3.b3", 16'd1,   16'd0, 2'b00, 2'b00);
        beat("t3.b4", 16'(-1), 16'd0, 2'b00, 2'b00);
        beat("t3.b5", 16'd1,   16'd0, 2'b01, 2'b00);
        beat("t3.b6", 16'(-1), 16'd0, 2'b00, 2'b00);

        // Back-pressure on a trigger beat; holdoff=2 exposes any counter movement while stalled.
        do_reset(16'd0, 16'd0, 16'd0, 16'd0, 16'd2);
        beat("t4.b0", 16'(-5), 16'd0, 2'b00, 2'b00);
        beat("t4.b1", 16'd0,   16'd0, 2'b01, 2'b00);
        m_tready = 1'b0;
        s_tdata  = {16'd0, 16'd5};
        s_tvalid = 1'b1;
        #1;
        check("t4.stall_ready", 64'(s_tready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge stream_clk);
            #1;
            check("t4.stall_valid", 64'(m_tvalid), 64'd1);
            check("t4.stall_data",  64'(m_tdata), 64'h0000_0000);
            check("t4.stall_rise",  64'(trig_rising), 64'd1);
            check("t4.stall_ready", 64'(s_tready), 64'd0);
        end
        m_tready = 1'b1;
        @(posedge stream_clk);
        #1;
        check("t4.rel_valid", 64'(m_tvalid), 64'd1);
        check("t4.rel_data",  64'(m_tdata), 64'h0000_0005);
        check("t4.rel_rise",  64'(trig_rising), 64'd0);
        s_tvalid = 1'b0;
        @(posedge stream_clk);
        #1;
        check("t4.idle_valid", 64'(m_tvalid), 64'd0);
        check("t4.idle_any",   64'(trig_any), 64'd0);
        beat("t4.b2", 16'(-5), 16'd0, 2'b00, 2'b00);
        beat("t4.b3", 16'd5,   16'd0, 2'b01, 2'b00);

        // Extreme thresholds: ch0 L=32767, ch1 L=-32768, h=100 on both.
        do_reset(16'h7FFF, 16'h8000, 16'd100, 16'd100, 16'd0);
        beat("t5.b0", 16'h8000, 16'h7FFF, 2'b00, 2'b00);
        beat("t5.b1", 16'h7FFF, 16'h8000, 2'b01, 2'b10);
        beat("t5.b2", 16'h7FFF, 16'h8000, 2'b00, 2'b00);

        // Random traffic against the reference model with a reset pulse mid-run.
        do_reset(16'd0, 16'd5, 16'd10, 16'd3, 16'd2);
        model_reset();
        sbq.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc == 200) begin
                resetn   = 1'b0;
                s_tvalid = 1'b0;
                #1;
                check("t6.rst_valid", 64'(m_tvalid), 64'd0);
                check("t6.rst_any",   64'(trig_any), 64'd0);
                check("t6.rst_rise",  64'(trig_rising), 64'd0);
                sbq.delete();
                model_reset();
                @(negedge stream_clk);
                resetn = 1'b1;
                @(posedge stream_clk);
                #1;
            end
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata  = {16'(int'($urandom_range(0, 60)) - 30), 16'(int'($urandom_range(0, 60)) - 30)};
            m_tready = ($urandom_range(0, 1) != 0);
            sb_cycle();
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int k = 0; k < 4; k++) sb_cycle();
        check("t6.drain", 64'(sbq.size()), 64'd0);
        check("t6.traffic", 64'(n_popped > 100), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
